// File: rtl/core_pkg.sv
// Shared core definitions: result-source encodings, load formats, defaults.
// Imported by the write-back stage and the load aligner.
package core_pkg;

    localparam int DEF_XLEN = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_IMM = 2'd3
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the byte/half/word at addr_lo
// and sign/zero-extends it; flags misaligned or unknown formats.
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;

    assign shifted = raw >> {addr_lo, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = shifted[15:0];

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        unique case (1'b1)
            funct3 == F3_LB: begin
                data = XLEN'($signed(byte_v));
            end
            funct3 == F3_LBU: begin
                data = XLEN'(byte_v);
            end
            funct3 == F3_LH: begin
                if (addr_lo[0]) misalign = 1'b1;
                else            data = XLEN'($signed(half_v));
            end
            funct3 == F3_LHU: begin
                if (addr_lo[0]) misalign = 1'b1;
                else            data = XLEN'(half_v);
            end
            funct3 == F3_LW: begin
                if (addr_lo != 2'b00) misalign = 1'b1;
                else                  data = raw;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_result_stage.sv
// Registered write-back stage: latches MEM/WB, selects and aligns the
// result, drives the regfile port, counts retires and tracks errors.
module wb_result_stage
    import core_pkg::*;
#(
    parameter  int XLEN     = DEF_XLEN,
    parameter  int NSRC     = 4,
    parameter  int LOAD_IDX = int'(RES_MEM),
    parameter  int RA_W     = 5,
    parameter  int CNT_W    = 32,
    localparam int SEL_W    = sel_width(NSRC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [SEL_W-1:0]     in_result_src,
    input  logic [NSRC*XLEN-1:0] in_src_data,
    input  logic                 in_reg_write,
    input  logic [RA_W-1:0]      in_rd,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    output logic                 wb_we,
    output logic [RA_W-1:0]      wb_rd,
    output logic [XLEN-1:0]      wb_result,
    output logic                 wb_valid,
    output logic                 err_sel,
    output logic                 err_misalign,
    output logic [CNT_W-1:0]     retire_cnt
);

    logic                 valid_q;
    logic                 rw_q;
    logic [RA_W-1:0]      rd_q;
    logic [SEL_W-1:0]     sel_q;
    logic [NSRC*XLEN-1:0] data_q;
    logic [2:0]           f3_q;
    logic [1:0]           lo_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 err_sel_q;
    logic                 err_mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            rd_q    <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q <= in_valid;
            rw_q    <= in_reg_write;
            rd_q    <= in_rd;
            sel_q   <= in_result_src;
            data_q  <= in_src_data;
            f3_q    <= in_funct3;
            lo_q    <= in_addr_lo;
        end
    end

    logic            sel_bad;
    logic            is_load;
    logic [XLEN-1:0] src_word;
    logic [XLEN-1:0] load_data;
    logic            load_mis;
    logic [XLEN-1:0] result;

    // Widen before comparing so a power-of-two NSRC never aliases to 0.
    assign sel_bad = {1'b0, sel_q} >= (SEL_W + 1)'(NSRC);
    assign is_load = sel_q == SEL_W'(LOAD_IDX);

    always_comb begin
        src_word = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel_q == SEL_W'(k)) src_word = data_q[k*XLEN +: XLEN];
        end
    end

    load_align #(
        .XLEN(XLEN)
    ) u_align (
        .raw     (data_q[LOAD_IDX*XLEN +: XLEN]),
        .funct3  (f3_q),
        .addr_lo (lo_q),
        .data    (load_data),
        .misalign(load_mis)
    );

    always_comb begin
        result = '0;
        unique case (1'b1)
            sel_bad: result = '0;
            is_load: result = load_data;
            default: result = src_word;
        endcase
    end

    logic bad_now;
    logic mis_now;
    logic retire;

    assign bad_now = valid_q & sel_bad;
    assign mis_now = valid_q & is_load & load_mis;
    assign retire  = valid_q & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            err_sel_q <= 1'b0;
            err_mis_q <= 1'b0;
        end else begin
            if (retire)  cnt_q     <= cnt_q + 1'b1;
            if (bad_now) err_sel_q <= 1'b1;
            if (mis_now) err_mis_q <= 1'b1;
        end
    end

    assign wb_valid     = valid_q;
    assign wb_we        = valid_q & rw_q & (rd_q != '0);
    assign wb_rd        = rd_q;
    assign wb_result    = result;
    assign err_sel      = err_sel_q | bad_now;
    assign err_misalign = err_mis_q | mis_now;
    assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_wb_result_stage.sv
// Bench for wb_result_stage: directed plan plus random traffic against
// a spec-level model; a second NSRC=3 instance covers bad selects.
module tb_wb_result_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall;
    logic         flush;
    logic         in_valid;
    logic [1:0]   in_result_src;
    logic [127:0] in_src_data;
    logic         in_reg_write;
    logic [4:0]   in_rd;
    logic [2:0]   in_funct3;
    logic [1:0]   in_addr_lo;

    logic        wb_we, wb_valid, err_sel, err_misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result, retire_cnt;

    logic        wb_we3, wb_valid3, err_sel3, err_misalign3;
    logic [4:0]  wb_rd3;
    logic [31:0] wb_result3, retire_cnt3;

    always #5 clk = ~clk;

    wb_result_stage #(.NSRC(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_result_src(in_result_src),
        .in_src_data(in_src_data), .in_reg_write(in_reg_write),
        .in_rd(in_rd), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_result(wb_result),
        .wb_valid(wb_valid), .err_sel(err_sel),
        .err_misalign(err_misalign), .retire_cnt(retire_cnt)
    );

    wb_result_stage #(.NSRC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_result_src(in_result_src),
        .in_src_data(in_src_data[95:0]), .in_reg_write(in_reg_write),
        .in_rd(in_rd), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .wb_we(wb_we3), .wb_rd(wb_rd3), .wb_result(wb_result3),
        .wb_valid(wb_valid3), .err_sel(err_sel3),
        .err_misalign(err_misalign3), .retire_cnt(retire_cnt3)
    );

    int checks = 0;
    int errors = 0;

    // Model of the instruction sitting in the stage.
    bit          m_valid, m_rw;
    int          m_rd, m_sel, m_f3, m_lo;
    int unsigned m_src[4];
    int unsigned m_cnt;
    bit          m_mis_st, m_sel3_st;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned exp_result(input int nsrc,
                                               output bit bad,
                                               output bit mis);
        int unsigned w, b, h;
        bad = 0;
        mis = 0;
        if (m_sel >= nsrc) begin
            bad = 1;
            return 0;
        end
        if (m_sel != 1) return m_src[m_sel];
        w = m_src[1];
        b = (w >> (8 * m_lo)) % 256;
        h = (w >> (8 * m_lo)) % 65536;
        case (m_f3)
            0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            4: return b;
            1: begin
                if (m_lo % 2 != 0) begin mis = 1; return 0; end
                return (h >= 32768) ? h + 32'hFFFF0000 : h;
            end
            5: begin
                if (m_lo % 2 != 0) begin mis = 1; return 0; end
                return h;
            end
            2: begin
                if (m_lo != 0) begin mis = 1; return 0; end
                return w;
            end
            default: begin mis = 1; return 0; end
        endcase
    endfunction

    task automatic check_all();
        int unsigned r4, r3;
        bit bad4, mis4, bad3, mis3;
        bit we;
        r4 = exp_result(4, bad4, mis4);
        r3 = exp_result(3, bad3, mis3);
        if (m_valid && mis4) m_mis_st = 1;
        if (m_valid && bad3) m_sel3_st = 1;
        we = m_valid && m_rw && (m_rd != 0);
        chk("valid", 32'(wb_valid), 32'(m_valid));
        chk("we", 32'(wb_we), 32'(we));
        chk("cnt", retire_cnt, m_cnt);
        chk("err_sel", 32'(err_sel), 32'(0));
        chk("err_mis", 32'(err_misalign), 32'(m_mis_st));
        chk("we3", 32'(wb_we3), 32'(we));
        chk("cnt3", retire_cnt3, m_cnt);
        chk("err_sel3", 32'(err_sel3), 32'(m_sel3_st));
        chk("err_mis3", 32'(err_misalign3), 32'(m_mis_st));
        if (m_valid) begin
            chk("result", wb_result, r4);
            chk("result3", wb_result3, r3);
            chk("rd", 32'(wb_rd), 32'(m_rd));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_valid && !stall && !flush) m_cnt++;
        if (flush) begin
            m_valid = 0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_rw    = in_reg_write;
            m_rd    = int'(in_rd);
            m_sel   = int'(in_result_src);
            m_f3    = int'(in_funct3);
            m_lo    = int'(in_addr_lo);
            for (int k = 0; k < 4; k++) m_src[k] = in_src_data[k*32 +: 32];
        end
        #1;
        check_all();
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0; m_lo = 0;
        for (int k = 0; k < 4; k++) m_src[k] = 0;
        m_cnt = 0; m_mis_st = 0; m_sel3_st = 0;
    endtask

    task automatic drive(input bit v, input int sel, input int rd,
                         input int f3, input int lo);
        in_valid      = v;
        in_reg_write  = 1'b1;
        in_result_src = 2'(sel);
        in_rd         = 5'(rd);
        in_funct3     = 3'(f3);
        in_addr_lo    = 2'(lo);
    endtask

    task automatic set_src(input int k, input logic [31:0] val);
        in_src_data[k*32 +: 32] = val;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("rst_result", wb_result, 32'h0);
        chk("rst_rd", 32'(wb_rd), 32'h0);
        check_all();
        #2;
        rst_n = 1'b1;
    endtask

    int unsigned c0;
    logic [31:0] held;

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        in_src_data = '0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk("rst_result", wb_result, 32'h0);
        check_all();
        rst_n = 1'b1;

        // Reset mid-stream discards a held ALU write.
        set_src(0, 32'h0000_5555);
        drive(1, 0, 5, 2, 0);
        tick();
        chk("pre_rst_we", 32'(wb_we), 32'h1);
        stall = 1'b1;
        tick();
        #2;
        stall = 1'b0;
        do_reset();

        // Each source in turn.
        set_src(0, 32'h1111_1111);
        set_src(1, 32'hDEAD_BEEF);
        set_src(2, 32'h0000_0104);
        set_src(3, 32'hFFFF_F000);
        c0 = m_cnt;
        for (int k = 0; k < 4; k++) begin
            drive(1, k, 3, 2, 0);
            tick();
            chk("src_we", 32'(wb_we), 32'h1);
        end
        chk("src3_val", wb_result, 32'hFFFF_F000);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("src_cnt", retire_cnt, c0 + 4);

        // Load alignment on source 1.
        set_src(1, 32'h80FF_7F01);
        drive(1, 1, 4, 0, 3); tick();
        chk("lb3", wb_result, 32'hFFFF_FF80);
        drive(1, 1, 4, 4, 2); tick();
        chk("lbu2", wb_result, 32'h0000_00FF);
        drive(1, 1, 4, 1, 2); tick();
        chk("lh2", wb_result, 32'hFFFF_80FF);
        drive(1, 1, 4, 5, 0); tick();
        chk("lhu0", wb_result, 32'h0000_7F01);
        drive(1, 1, 4, 1, 1); tick();
        chk("lh1_res", wb_result, 32'h0);
        chk("lh1_err", 32'(err_misalign), 32'h1);

        // Write to x0 is suppressed but still retires.
        set_src(0, 32'h0000_1234);
        drive(1, 0, 0, 2, 0); tick();
        chk("x0_we", 32'(wb_we), 32'h0);
        c0 = retire_cnt;
        drive(0, 0, 0, 0, 0); tick();
        chk("x0_cnt", retire_cnt, c0 + 1);

        // Stall holds; stall+flush empties.
        set_src(0, 32'h0BAD_F00D);
        drive(1, 0, 7, 2, 0); tick();
        held = wb_result;
        c0 = retire_cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_src(0, $urandom);
            drive(1, 0, 9, 2, 0);
            tick();
            chk("stall_res", wb_result, held);
            chk("stall_cnt", retire_cnt, c0);
            chk("stall_rd", 32'(wb_rd), 32'd7);
        end
        flush = 1'b1;
        tick();
        chk("sf_valid", 32'(wb_valid), 32'h0);
        chk("sf_we", 32'(wb_we), 32'h0);
        stall = 1'b0; flush = 1'b0;

        // Out-of-range select on the NSRC=3 build is sticky.
        set_src(3, 32'h0000_ABCD);
        drive(1, 3, 9, 2, 0); tick();
        chk("sel3_res3", wb_result3, 32'h0);
        chk("sel3_err3", 32'(err_sel3), 32'h1);
        chk("sel3_res4", wb_result, 32'h0000_ABCD);
        for (int i = 0; i < 3; i++) begin
            drive(1, i, 2, 2, 0); tick();
        end
        chk("sel3_sticky", 32'(err_sel3), 32'h1);
        #2;
        do_reset();
        chk("sel3_clr", 32'(err_sel3), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) set_src(k, $urandom);
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                  $urandom_range(0, 31), $urandom_range(0, 7),
                  $urandom_range(0, 3));
            in_reg_write = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            tick();
            if (i == 200) begin
                #2;
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
